// File: rtl/mem_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_pkg
//   Definitions shared by the memory access controller, the memory subsystem
//   and the control unit.
//   - state_t            : encoding of the access sequencer states
//   - default parameters : RAM latency and RAM word-address width
//   - addr_out_of_range  : true when a CPU address lies beyond the RAM words
// -----------------------------------------------------------------------------
package mem_access_ctrl_pkg;

    // CPU-side effective address width.
    localparam int unsigned CPU_ADDR_W = 32;

    // Defaults used when a parent does not override the parameters.
    localparam int unsigned RAM_LATENCY_DEFAULT = 1;
    localparam int unsigned ADDR_W_DEFAULT      = 9;

    // The eight states fill the 3-bit encoding space.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_RD   = 3'd2,
        ST_CAPT = 3'd3,
        ST_DATA = 3'd4,
        ST_WR   = 3'd5,
        ST_DONE = 3'd6,
        ST_FLT  = 3'd7
    } state_t;

    // Any set bit at or above the RAM word-address width means the address
    // does not exist in RAM.
    function automatic logic addr_out_of_range(
        input logic [CPU_ADDR_W-1:0] addr,
        input int unsigned           addr_w
    );
        return (addr >> addr_w) != '0;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// -----------------------------------------------------------------------------
// mem_wait_counter
//   Loadable down-counter that times how long RAM read/write stays asserted.
//   Decrements only from a non-zero value, so it never wraps.
//
// Ports
//   clock      in   rising-edge clock
//   clear      in   asynchronous active-high clear, count -> 0
//   load       in   load load_value (takes priority over dec)
//   load_value in   value loaded when load=1
//   dec        in   decrement request, ignored while count is zero
//   zero       out  count == 0
// -----------------------------------------------------------------------------
module mem_wait_counter #(
    parameter int unsigned CNT_W = 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//   Initiator side of the CPU memory path. Sequences MAR/MDR/RAM strobes for
//   a single load or store, tells the bus mux what to drive, hides the RAM
//   wait cycles and rejects addresses beyond the RAM word range.
//
//   Load : IDLE -> ADDR -> RD (x RAM_LATENCY) -> CAPT -> DONE -> IDLE
//   Store: IDLE -> ADDR -> DATA -> WR (x RAM_LATENCY) -> DONE -> IDLE
//   Fault: IDLE -> FLT -> IDLE
//
// Ports
//   clock        in   system clock, rising edge
//   clear        in   asynchronous active-high reset
//   req          in   access request, sampled only while ready=1
//   we           in   1=store, 0=load, sampled with req
//   addr_in      in   32-bit effective address, sampled with req
//   ready        out  idle, able to accept req
//   MARin        out  load MAR from the bus
//   MDRin        out  load MDR (memory when read=1, bus otherwise)
//   read         out  RAM read enable / MDR source select
//   write        out  RAM write enable
//   bus_sel_addr out  bus mux drives the latched address
//   bus_sel_data out  bus mux drives the store data
//   done         out  one-cycle pulse, access finished
//   fault        out  one-cycle pulse with done, address out of range
//
// All outputs are decoded from the registered state only; req/addr_in never
// reach an output combinationally.
// -----------------------------------------------------------------------------
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned RAM_LATENCY = RAM_LATENCY_DEFAULT,
    parameter int unsigned ADDR_W      = ADDR_W_DEFAULT
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  req,
    input  logic                  we,
    input  logic [CPU_ADDR_W-1:0] addr_in,
    output logic                  ready,
    output logic                  MARin,
    output logic                  MDRin,
    output logic                  read,
    output logic                  write,
    output logic                  bus_sel_addr,
    output logic                  bus_sel_data,
    output logic                  done,
    output logic                  fault
);

    localparam int unsigned CNT_W = $clog2(RAM_LATENCY + 1);

    // RD/WR last one cycle for the loaded value plus one for each decrement,
    // so loading RAM_LATENCY-1 gives exactly RAM_LATENCY strobe cycles.
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RAM_LATENCY - 1);

    state_t state;
    state_t state_next;
    logic   we_lat;
    logic   out_of_range;
    logic   cnt_load;
    logic   cnt_dec;
    logic   cnt_zero;

    assign out_of_range = addr_out_of_range(addr_in, ADDR_W);

    // ------------------------------------------------------------------------
    // State register and request latch
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state  <= ST_IDLE;
            we_lat <= 1'b0;
        end else begin
            state <= state_next;
            if ((state == ST_IDLE) && req) begin
                we_lat <= we;
            end
        end
    end

    // ------------------------------------------------------------------------
    // RAM wait timer shared by the RD and WR states
    // ------------------------------------------------------------------------
    mem_wait_counter #(
        .CNT_W (CNT_W)
    ) u_wait (
        .clock      (clock),
        .clear      (clear),
        .load       (cnt_load),
        .load_value (WAIT_LOAD),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    // ------------------------------------------------------------------------
    // Next state and Moore output decode
    // ------------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        ready        = 1'b0;
        MARin        = 1'b0;
        MDRin        = 1'b0;
        read         = 1'b0;
        write        = 1'b0;
        bus_sel_addr = 1'b0;
        bus_sel_data = 1'b0;
        done         = 1'b0;
        fault        = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;

        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (req) begin
                    // Out-of-range addresses never touch MAR or RAM.
                    state_next = out_of_range ? ST_FLT : ST_ADDR;
                end
            end

            ST_ADDR: begin
                MARin        = 1'b1;
                bus_sel_addr = 1'b1;
                cnt_load     = 1'b1;
                state_next   = we_lat ? ST_DATA : ST_RD;
            end

            ST_RD: begin
                read = 1'b1;
                if (cnt_zero) begin
                    state_next = ST_CAPT;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            ST_CAPT: begin
                // read stays high so the RAM output is still valid as MDR
                // captures it.
                read       = 1'b1;
                MDRin      = 1'b1;
                state_next = ST_DONE;
            end

            ST_DATA: begin
                // read=0 steers the MDR input mux to the bus.
                MDRin        = 1'b1;
                bus_sel_data = 1'b1;
                cnt_load     = 1'b1;
                state_next   = ST_WR;
            end

            ST_WR: begin
                write = 1'b1;
                if (cnt_zero) begin
                    state_next = ST_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end

            ST_FLT: begin
                done       = 1'b1;
                fault      = 1'b1;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//   Two controllers (RAM_LATENCY 1 and 3), each with a small MAR/MDR/RAM
//   datapath model. Transactions are pushed to a scoreboard when driven;
//   the monitor compares per-cycle strobes, latency and data on completion.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

    localparam int AW = 9;

    typedef struct {
        int          unit;
        bit          w;
        bit          flt;
        logic [8:0]  a;
        logic [31:0] d;
        bit          chk_gap;
    } txn_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        clear   [2];
    logic        req     [2];
    logic        we      [2];
    logic [31:0] addr_in [2];
    logic        ready   [2];
    logic        marin   [2];
    logic        mdrin   [2];
    logic        rd      [2];
    logic        wr      [2];
    logic        bsa     [2];
    logic        bsd     [2];
    logic        done    [2];
    logic        fault   [2];

    mem_access_ctrl #(.RAM_LATENCY(1), .ADDR_W(AW)) dut_l1 (
        .clock(clock), .clear(clear[0]), .req(req[0]), .we(we[0]), .addr_in(addr_in[0]),
        .ready(ready[0]), .MARin(marin[0]), .MDRin(mdrin[0]), .read(rd[0]), .write(wr[0]),
        .bus_sel_addr(bsa[0]), .bus_sel_data(bsd[0]), .done(done[0]), .fault(fault[0])
    );

    mem_access_ctrl #(.RAM_LATENCY(3), .ADDR_W(AW)) dut_l3 (
        .clock(clock), .clear(clear[1]), .req(req[1]), .we(we[1]), .addr_in(addr_in[1]),
        .ready(ready[1]), .MARin(marin[1]), .MDRin(mdrin[1]), .read(rd[1]), .write(wr[1]),
        .bus_sel_addr(bsa[1]), .bus_sel_data(bsd[1]), .done(done[1]), .fault(fault[1])
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] init_word(input int u, input int i);
        return 32'hC0DE_0000 ^ 32'(u * 4096) ^ 32'(i);
    endfunction

    function automatic int lat_of(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    function automatic int exp_lat(input txn_t e);
        return e.flt ? 1 : lat_of(e.unit) + 3;
    endfunction

    // {ready, MARin, MDRin, read, write, bus_sel_addr, bus_sel_data, done, fault}
    function automatic logic [8:0] exp_vec(input txn_t e, input int k);
        int lat;
        logic [8:0] v;
        lat = lat_of(e.unit);
        v = '0;
        if (e.flt) begin
            if (k == 1) v = 9'b0_0000_0011;
        end else if (k == 1) begin
            v = 9'b0_1000_1000;
        end else if (!e.w) begin
            if (k >= 2 && k <= lat + 1) v = 9'b0_0010_0000;
            else if (k == lat + 2)      v = 9'b0_0110_0000;
            else if (k == lat + 3)      v = 9'b0_0000_0010;
        end else begin
            if (k == 2)                     v = 9'b0_0100_0100;
            else if (k >= 3 && k <= lat + 2) v = 9'b0_0001_0000;
            else if (k == lat + 3)          v = 9'b0_0000_0010;
        end
        return v;
    endfunction

    // ---------------- datapath model: address latch, MAR, MDR, RAM ----------
    logic [31:0] ram     [2][512];
    logic [31:0] exp_mem [2][512];
    logic [8:0]  mar     [2];
    logic [31:0] mdr     [2];
    logic [31:0] alat    [2];
    logic [31:0] dlat    [2];
    logic [31:0] sdata   [2];
    logic        mem_init = 1'b0;

    always @(posedge clock) begin
        for (int u = 0; u < 2; u++) begin
            logic [31:0] bus;
            bus = bsa[u] ? alat[u] : (bsd[u] ? dlat[u] : 32'h0);
            if (!mem_init) begin
                for (int i = 0; i < 512; i++) ram[u][i] <= init_word(u, i);
            end else begin
                if (ready[u] && req[u]) begin
                    alat[u] <= addr_in[u];
                    dlat[u] <= sdata[u];
                end
                if (marin[u]) mar[u] <= bus[8:0];
                if (mdrin[u]) mdr[u] <= rd[u] ? ram[u][mar[u]] : bus;
                if (wr[u])    ram[u][mar[u]] <= mdr[u];
            end
        end
        mem_init <= 1'b1;
    end

    // ---------------- scoreboard and monitor --------------------------------
    txn_t sbq[$];
    int   cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    bit active    [2] = '{0, 0};
    int acc       [2] = '{0, 0};
    int last_done [2] = '{0, 0};
    bit prev_done [2] = '{0, 0};

    always @(negedge clock) begin
        for (int u = 0; u < 2; u++) begin
            logic [8:0] v;
            int k;
            txn_t e;
            v = {ready[u], marin[u], mdrin[u], rd[u], wr[u], bsa[u], bsd[u], done[u], fault[u]};
            if (clear[u]) begin
                active[u] <= 1'b0;
            end else begin
                chk("rd_wr_excl", 64'(rd[u] & wr[u]), 0);
                chk("bus_sel_excl", 64'(bsa[u] & bsd[u]), 0);
                chk("fault_implies_done", 64'(fault[u] & ~done[u]), 0);
                chk("done_single_pulse", 64'(done[u] & prev_done[u]), 0);
                if (active[u] && sbq.size() != 0 && sbq[0].unit == u) begin
                    e = sbq[0];
                    k = cyc - acc[u];
                    chk("strobe_profile", 64'(v), 64'(exp_vec(e, k)));
                    if (done[u]) begin
                        chk("latency", 64'(k), 64'(exp_lat(e)));
                        chk("fault_flag", 64'(fault[u]), 64'(e.flt));
                        if (e.flt)       chk("fault_ram_untouched", ram[u][e.a], exp_mem[u][e.a]);
                        else if (e.w)    chk("store_ram", ram[u][e.a], e.d);
                        else             chk("load_mdr", mdr[u], e.d);
                        void'(sbq.pop_front());
                        active[u]    <= 1'b0;
                        last_done[u] <= cyc;
                    end else if (k >= exp_lat(e)) begin
                        chk("done_missing", 0, 1);
                        void'(sbq.pop_front());
                        active[u] <= 1'b0;
                    end
                end else if (done[u]) begin
                    chk("spurious_done", 1, 0);
                end
                if (!active[u] && ready[u] && req[u] && sbq.size() != 0 && sbq[0].unit == u) begin
                    acc[u]    <= cyc;
                    active[u] <= 1'b1;
                    if (sbq[0].chk_gap) chk("b2b_gap", 64'(cyc - last_done[u]), 1);
                end
            end
            prev_done[u] <= done[u];
        end
    end

    // ---------------- driver ------------------------------------------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Sets the request and returns once the DUT has taken it (req left high).
    task automatic issue(input int u, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input bit gap);
        txn_t e;
        int n;
        e.unit = u; e.w = w; e.flt = (a >= 32'd512); e.a = a[8:0]; e.chk_gap = gap;
        e.d = w ? d : exp_mem[u][a[8:0]];
        if (w && !e.flt) exp_mem[u][a[8:0]] = d;
        sbq.push_back(e);
        req[u] = 1'b1; we[u] = w; addr_in[u] = a; sdata[u] = d;
        n = 0;
        while (!ready[u] && n < 50) begin step(); n++; end
        n = 0;
        while (ready[u] && n < 50) begin step(); n++; end
        if (ready[u]) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 60) begin step(); n++; end
        if (sbq.size() != 0) begin
            chk("drain_timeout", 0, 1);
            sbq.delete();
        end
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            clear[u] = 1'b1; req[u] = 1'b0; we[u] = 1'b0; addr_in[u] = '0; sdata[u] = '0;
            for (int i = 0; i < 512; i++) exp_mem[u][i] = init_word(u, i);
        end
        repeat (3) step();
        for (int u = 0; u < 2; u++) begin
            chk("reset_ready", 64'(ready[u]), 1);
            chk("reset_outputs", 64'({marin[u], mdrin[u], rd[u], wr[u], bsa[u], bsd[u], done[u], fault[u]}), 0);
        end
        clear[0] = 1'b0; clear[1] = 1'b0;
        step();

        // RAM_LATENCY=1: load, faults, store then readback
        issue(0, 0, 32'h0000_0010, 32'h0, 0); req[0] = 1'b0; drain();
        issue(0, 0, 32'h0000_0200, 32'h0, 0); req[0] = 1'b0; drain();
        issue(0, 1, 32'h8000_0004, 32'h5555_AAAA, 0); req[0] = 1'b0; drain();
        issue(0, 1, 32'h0000_0055, 32'h1234_5678, 0); req[0] = 1'b0; drain();
        issue(0, 0, 32'h0000_0055, 32'h0, 0); req[0] = 1'b0; drain();

        // RAM_LATENCY=3: store to top word, readback, plain load
        issue(1, 1, 32'h0000_01FF, 32'hDEAD_BEEF, 0); req[1] = 1'b0; drain();
        issue(1, 0, 32'h0000_01FF, 32'h0, 0); req[1] = 1'b0; drain();
        issue(1, 0, 32'h0000_00AA, 32'h0, 0); req[1] = 1'b0; drain();

        // Busy: a store request pulsed mid-load must be ignored
        issue(1, 0, 32'h0000_0040, 32'h0, 0);
        req[1] = 1'b0; step();
        req[1] = 1'b1; we[1] = 1'b1; addr_in[1] = 32'h33; sdata[1] = 32'hBAD0_BAD0;
        step();
        req[1] = 1'b0; we[1] = 1'b0;
        drain();
        repeat (3) step();
        chk("busy_ignored_ram", ram[1][9'h033], exp_mem[1][9'h033]);

        // Back-to-back with req held high: store, load, fault
        issue(0, 1, 32'h0000_0101, 32'hCAFE_F00D, 0);
        issue(0, 0, 32'h0000_0101, 32'h0, 1);
        issue(0, 0, 32'h0000_0300, 32'h0, 1);
        req[0] = 1'b0; drain();

        // Asynchronous clear in the middle of a read
        req[1] = 1'b1; we[1] = 1'b0; addr_in[1] = 32'h20;
        for (int n = 0; n < 20 && !rd[1]; n++) step();
        chk("reached_rd", 64'(rd[1]), 1);
        req[1] = 1'b0;
        #1 clear[1] = 1'b1;
        #1;
        chk("clear_ready", 64'(ready[1]), 1);
        chk("clear_read", 64'(rd[1]), 0);
        chk("clear_marin", 64'(marin[1]), 0);
        step(); step();
        clear[1] = 1'b0;
        repeat (10) step();
        chk("post_clear_ready", 64'(ready[1]), 1);
        issue(1, 0, 32'h0000_0020, 32'h0, 0); req[1] = 1'b0; drain();

        repeat (2) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
